// File: rtl/catv_pkg.sv
// Shared types and constants for the catv_riscv instruction fetch path.
package catv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INSN_BYTES = 4;

    // Clears the byte-offset bits of a redirect target
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(INSN_BYTES - 1);

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] insn;
    } fetch_entry_t;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/catv_fetch_fifo.sv
// Synchronous FIFO of fetched {pc, insn} entries; flush overrides push and pop.
module catv_fetch_fifo
    import catv_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

    // A pop frees the head slot, so push at full is legal in the same cycle
    assign w_pop  = pop && !empty && !flush;
    assign w_push = push && (!full || w_pop) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is reset so the head reads as zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/catv_prefetch_buffer.sv
// Instruction fetch stage: sequential bus requests, response buffering,
// decode handshake and redirect flush.
module catv_prefetch_buffer
    import catv_pkg::*;
#(
    parameter int unsigned     DEPTH     = 4,
    parameter logic [XLEN-1:0] BOOT_ADDR = 32'h0000_0180
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_addr_i,
    output logic            fetch_valid_o,
    input  logic            fetch_ready_i,
    output logic [XLEN-1:0] fetch_insn_o,
    output logic [XLEN-1:0] fetch_addr_o,
    output logic [XLEN-1:0] insn_addr_o,
    output logic            insn_valid_o,
    input  logic            insn_ready_i,
    input  logic [XLEN-1:0] insn_data_i,
    input  logic            insn_rvalid_i
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_addr;
    logic            r_outstanding;

    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_inflight;
    fetch_entry_t    w_wdata;
    fetch_entry_t    w_head;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: leave IDLE on the first edge after reset, then stay in RUN
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            FETCH_IDLE: w_state_next = FETCH_RUN;
            FETCH_RUN:  w_state_next = FETCH_RUN;
            default:    w_state_next = FETCH_IDLE;
        endcase
    end

    // Buffered entries plus the one possible in-flight response bound the issue
    assign w_inflight = w_count + CW'(r_outstanding);

    // Output decode
    always_comb begin
        insn_valid_o = 1'b0;
        unique case (r_state)
            FETCH_RUN: insn_valid_o = !branch_i && (w_inflight < CW'(DEPTH));
            default:   insn_valid_o = 1'b0;
        endcase
    end

    assign w_accept    = insn_valid_o && insn_ready_i;
    assign insn_addr_o = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= BOOT_ADDR;
            r_req_addr    <= BOOT_ADDR;
            r_outstanding <= 1'b0;
        end else begin
            r_outstanding <= w_accept;
            if (w_accept) begin
                r_req_addr <= r_pc;
            end
            if (branch_i) begin
                r_pc <= branch_addr_i & WORD_MASK;
            end else if (w_accept) begin
                r_pc <= r_pc + XLEN'(INSN_BYTES);
            end
        end
    end

    // A redirect voids both the response and the decode handshake of its cycle
    assign w_push  = insn_rvalid_i && r_outstanding && !branch_i;
    assign w_pop   = fetch_valid_o && fetch_ready_i && !branch_i;
    assign w_wdata = '{addr: r_req_addr, insn: insn_data_i};

    catv_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (branch_i),
        .wdata (w_wdata),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign fetch_valid_o = !w_empty;
    assign fetch_insn_o  = w_head.insn;
    assign fetch_addr_o  = w_head.addr;

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        insn_rvalid_i |-> r_outstanding);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        w_push |-> (!w_full || w_pop));

endmodule
